// File: rtl/expr_ci_pkg.sv
// expr_ci_pkg: opcodes, FSM states and FP helpers shared by the
// expr custom-instruction controller and its core models.
package expr_ci_pkg;

    localparam logic [1:0] OP_CLR      = 2'd0;
    localparam logic [1:0] OP_EVAL     = 2'd1;
    localparam logic [1:0] OP_EVAL_ACC = 2'd2;
    localparam logic [1:0] OP_READ     = 2'd3;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ACC,
        S_DONE
    } state_t;

    // Single -> double by re-biasing the exponent; denormals flush to 0.
    function automatic real sp_to_real(input logic [31:0] s);
        logic [10:0] e;
        logic [63:0] d;
        if (s[30:23] == 8'h00) begin
            d = {s[31], 63'b0};
        end else if (s[30:23] == 8'hFF) begin
            d = {s[31], 11'h7FF, s[22:0], 29'b0};
        end else begin
            e = {3'b000, s[30:23]} + 11'd896;
            d = {s[31], e, s[22:0], 29'b0};
        end
        return $bitstoreal(d);
    endfunction

    // Double -> single, round to nearest even; the mantissa carry
    // ripples into the exponent, which also handles overflow to Inf.
    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [10:0] eb;
        logic        inc;
        logic [30:0] mag;
        d   = $realtobits(r);
        e   = d[62:52];
        inc = d[28] & ((|d[27:0]) | d[29]);
        if (e == 11'h7FF) begin
            return {d[63], 8'hFF, d[51:29]};
        end else if (e >= 11'd1151) begin
            return {d[63], 8'hFF, 23'b0};
        end else if (e <= 11'd896) begin
            return {d[63], 31'b0};
        end
        eb  = e - 11'd896;
        mag = {eb[7:0], d[51:29]} + {30'b0, inc};
        return {d[63], mag};
    endfunction

endpackage

// File: rtl/expr.sv
// expr: model of the vendor core f(x) = x*(x*cos(x/128-1)+0.5).
// Ports: clk, reset, x (held stable), result (valid LAT cycles later).
module expr
    import expr_ci_pkg::*;
#(
    parameter int LAT = 56
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x,
    output logic [31:0] result
);

    logic [31:0] y;

    always_comb begin
        real xr;
        xr = sp_to_real(x);
        y  = real_to_sp(xr * (xr * $cos(xr / 128.0 - 1.0) + 0.5));
    end

    // The first cycle x is stable counts as cycle 1 of the latency.
    if (LAT > 1) begin : g_pipe
        logic [31:0] stage [LAT-1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LAT - 1; i++) stage[i] <= '0;
            end else begin
                stage[0] <= y;
                for (int i = 1; i < LAT - 1; i++) stage[i] <= stage[i-1];
            end
        end
        assign result = stage[LAT-2];
    end else begin : g_bypass
        assign result = y;
    end

endmodule

// File: rtl/fp_add.sv
// fp_add: model of the vendor single-precision adder IP.
// Ports: clk, reset, a, b (held stable), result (valid LAT cycles later).
module fp_add
    import expr_ci_pkg::*;
#(
    parameter int LAT = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    logic [31:0] y;

    always_comb begin
        y = real_to_sp(sp_to_real(a) + sp_to_real(b));
    end

    if (LAT > 1) begin : g_pipe
        logic [31:0] stage [LAT-1];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LAT - 1; i++) stage[i] <= '0;
            end else begin
                stage[0] <= y;
                for (int i = 1; i < LAT - 1; i++) stage[i] <= stage[i-1];
            end
        end
        assign result = stage[LAT-2];
    end else begin : g_bypass
        assign result = y;
    end

endmodule

// File: rtl/expr_ci.sv
// expr_ci: multi-cycle custom-instruction controller for the expr core.
// Ports: clk, reset, clk_en, start, n (opcode), dataa -> done, result.
module expr_ci
    import expr_ci_pkg::*;
#(
    parameter int EXPR_LAT = 56,
    parameter int ADD_LAT  = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result
);

    localparam int CNT_MAX = (EXPR_LAT > ADD_LAT) ? EXPR_LAT : ADD_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] EXPR_LAST = CW'(EXPR_LAT - 1);
    localparam logic [CW-1:0] ADD_LAST  = CW'(ADD_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [31:0] x_reg;
    logic [1:0]  op_reg;
    logic [31:0] f_reg;
    logic [31:0] acc;
    logic [31:0] res_q;
    logic [31:0] expr_y;
    logic [31:0] sum;
    logic        accept;
    logic        calc_end;
    logic        acc_end;

    assign accept   = (state == S_IDLE) && start && clk_en;
    assign calc_end = (state == S_CALC) && (cnt == EXPR_LAST);
    assign acc_end  = (state == S_ACC) && (cnt == ADD_LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    cnt_nx = '0;
                    if (n == OP_EVAL || n == OP_EVAL_ACC) state_nx = S_CALC;
                    else                                  state_nx = S_DONE;
                end
            end
            S_CALC: begin
                if (calc_end) begin
                    cnt_nx = '0;
                    if (op_reg == OP_EVAL_ACC) state_nx = S_ACC;
                    else                       state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_ACC: begin
                if (acc_end) begin
                    cnt_nx   = '0;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_DONE: begin
                if (clk_en) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            x_reg  <= FP_ZERO;
            op_reg <= OP_CLR;
            f_reg  <= FP_ZERO;
            acc    <= FP_ZERO;
            res_q  <= FP_ZERO;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                x_reg  <= dataa;
                op_reg <= n;
                if (n == OP_CLR) begin
                    acc   <= FP_ZERO;
                    res_q <= FP_ZERO;
                end
                if (n == OP_READ) res_q <= acc;
            end
            if (calc_end) begin
                f_reg <= expr_y;
                if (op_reg == OP_EVAL) res_q <= expr_y;
            end
            if (acc_end) begin
                acc   <= sum;
                res_q <= sum;
            end
        end
    end

    assign done   = (state == S_DONE);
    assign result = res_q;

    // Cores have no enable: x_reg, acc and f_reg stay put while they run.
    expr #(
        .LAT(EXPR_LAT)
    ) u_expr (
        .clk    (clk),
        .reset  (reset),
        .x      (x_reg),
        .result (expr_y)
    );

    fp_add #(
        .LAT(ADD_LAT)
    ) u_add (
        .clk    (clk),
        .reset  (reset),
        .a      (acc),
        .b      (f_reg),
        .result (sum)
    );

endmodule

// File: tb/tb_expr_ci.sv
// tb_expr_ci: directed self-checking bench for expr_ci.
// Ports: none; drives clk, reset, clk_en, start, n, dataa.
module tb_expr_ci;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int lat;
    int c;
    logic seen;

    always #5 clk = ~clk;

    expr_ci dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .done   (done),
        .result (result)
    );

    // Relative tolerance ~1e-4 expressed as mantissa LSBs.
    function automatic logic near(input logic [31:0] a, input logic [31:0] e);
        longint d;
        if ($isunknown(a)) return 1'b0;
        d = longint'(a) - longint'(e);
        if (d < 0) d = -d;
        return (a[31] == e[31]) && (d <= 838);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (near(obs, exp) === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%h expected~%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1;
        n     = op;
        dataa = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency in cycles: 1 means done in the cycle right after accept.
    task automatic wait_done(output int l);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        l = (done === 1'b1) ? k + 1 : -1;
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk);
        #1;
        chk(tag, {31'b0, done}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = 2'd0;
        dataa  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_done", {31'b0, done}, 32'd0);
            chk("idle_result", result, 32'h0);
        end

        issue(2'd1, 32'h4300_0000);
        wait_done(lat);
        chk("eval_lat", 32'(lat), 32'd57);
        chk_near("eval_128", result, 32'h4680_8000);
        pulse_end("eval_pulse");

        issue(2'd0, 32'hDEAD_BEEF);
        wait_done(lat);
        chk("clr_lat", 32'(lat), 32'd1);
        chk("clr_result", result, 32'h0);
        pulse_end("clr_pulse");

        issue(2'd2, 32'h4300_0000);
        wait_done(lat);
        chk("acc1_lat", 32'(lat), 32'd71);
        chk_near("acc1_result", result, 32'h4680_8000);
        pulse_end("acc1_pulse");

        issue(2'd2, 32'h4300_0000);
        wait_done(lat);
        chk("acc2_lat", 32'(lat), 32'd71);
        chk_near("acc2_result", result, 32'h4700_8000);
        pulse_end("acc2_pulse");

        issue(2'd3, 32'h1234_5678);
        wait_done(lat);
        chk("read_lat", 32'(lat), 32'd1);
        chk_near("read_result", result, 32'h4700_8000);
        pulse_end("read_pulse");

        issue(2'd1, 32'h0000_0000);
        wait_done(lat);
        chk("eval0_lat", 32'(lat), 32'd57);
        chk("eval0_result", result, 32'h0);
        pulse_end("eval0_pulse");

        issue(2'd1, 32'h4300_0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b1;
            n     = 2'($urandom_range(0, 3));
            dataa = $urandom;
            @(posedge clk);
            #1;
            chk("ign_done", {31'b0, done}, 32'd0);
            chk("ign_hold", result, 32'h0);
        end
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", 32'(lat + 20), 32'd57);
        chk_near("ign_result", result, 32'h4680_8000);
        pulse_end("ign_pulse");

        issue(2'd1, 32'h4380_0000);
        c = 0;
        while (done !== 1'b1 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 29) clk_en = 1'b0;
        end
        chk("stall_lat", 32'(c + 1), 32'd57);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold", {31'b0, done}, 32'd1);
        end
        chk_near("stall_result", result, 32'h470A_D140);
        clk_en = 1'b1;
        pulse_end("stall_exit");

        issue(2'd2, 32'h4300_0000);
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_result", result, 32'h0);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("abort_nodone", {31'b0, seen}, 32'd0);

        issue(2'd3, 32'h0);
        wait_done(lat);
        chk("read0_lat", 32'(lat), 32'd1);
        chk("read0_result", result, 32'h0);
        pulse_end("read0_pulse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/expr_ci.md
# expr_ci

Nios II extended multi-cycle custom-instruction controller that drives the `expr` core, which computes f(x) = x·(x·cos(x/128 − 1) + 0.5). It is the CPU-facing side of that datapath. It accepts an instruction from the processor and latches the operand for the full duration of the non-pipelined core. It counts out the fixed core latency, optionally accumulates results through an `fp_add`, and returns the value with a `done` pulse.

## Interface

Parameters:
- `EXPR_LAT`, default 56: cycles from `expr.x` stable to `expr.result` valid.
- `ADD_LAT`, default 14: latency of the configured `fp_add` IP, in cycles.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `clk_en`  in  1: CPU stall qualifier.
- `start`  in  1: instruction issue, sampled with `clk_en`.
- `n`  in  2: opcode.
- `dataa`  in  32: IEEE-754 single-precision operand x.
- `done`  out  1: result valid.
- `result`  out  32: IEEE-754 single-precision result.

## Operation

Opcodes on `n`:
- 0, CLR: acc ← +0.0; result = 0x00000000.
- 1, EVAL: result = f(dataa); acc unchanged.
- 2, EVAL_ACC: acc ← acc + f(dataa); result = new acc.
- 3, READ: result = acc.

FSM states: IDLE, CALC, ACC, DONE.
- IDLE:
  - Accept when `start & clk_en`.
  - Latch `dataa` into x_reg and `n` into op_reg.
  - Clear the latency counter.
  - CLR/READ go directly to DONE; EVAL/EVAL_ACC go to CALC.
- CALC:
  - x_reg feeds the `expr.x` input and is held constant throughout.
  - The counter increments each cycle.
  - At count = EXPR_LAT−1, capture the `expr` result into f_reg.
  - Then EVAL goes to DONE and EVAL_ACC goes to ACC.
- ACC:
  - `fp_add` inputs are acc and f_reg, held constant.
  - At count = ADD_LAT−1, capture the sum into acc.
  - Then go to DONE.
- DONE:
  - `done` = 1; `result` driven from the op-selected register.
  - Leave for IDLE on the first cycle with `clk_en` = 1.
  - `done` stays high while `clk_en` = 0.

Rules:
- `clk_en` gates only instruction acceptance and the DONE exit.
- CALC and ACC counters run regardless of `clk_en`, because the cores have no enable.
- `start` outside IDLE is ignored. No queueing.
- No special handling of NaN, Inf or denormals; core behaviour passes through.
- The counter is wide enough for max(EXPR_LAT, ADD_LAT); it never wraps within an operation.

## Timing

- Reset values: `done` = 0, `result` = 0x00000000, acc = 0x00000000, state = IDLE, counter = 0.
- Reset mid-operation:
  - Abort to IDLE; no `done` is produced.
  - acc is cleared.
  - Core pipelines are reset through their reset inputs, tied to `reset`.
- Accept at cycle T. `done` then rises at:
  - CLR/READ: T+1.
  - EVAL: T+1+EXPR_LAT.
  - EVAL_ACC: T+1+EXPR_LAT+ADD_LAT.
- `done` is a single-cycle pulse when `clk_en` = 1. Earliest next accept is the cycle after `done` falls.
- `result` holds its last value after `done` deasserts. It is registered; no combinational path from inputs.
- CLR's acc update is visible to an EVAL_ACC accepted in the next IDLE cycle.

## Structure

- Shared package `expr_ci_pkg` holds:
  - opcode constants OP_CLR, OP_EVAL, OP_EVAL_ACC, OP_READ;
  - the state enumeration;
  - FP constant FP_ZERO.
- Instantiates the existing `expr` and `fp_add` blocks. No new sub-module; the FSM and counter stay in this block.

## Test plan

Float comparisons allow CORDIC error of ≤1e-4 relative.
- Reset, then idle 10 cycles → `done` = 0 and `result` = 0x00000000 throughout.
- EVAL with dataa = 0x43000000 (128.0) → `done` exactly 57 cycles after accept; `result` ≈ 0x46808000 (16448.0).
- CLR, then EVAL_ACC 128.0 twice, then READ:
  - the EVAL_ACC returns ≈ 0x46808000, then ≈ 0x47008000;
  - READ returns ≈ 0x47008000 with `done` at T+1.
- EVAL dataa = 0x00000000 → result 0x00000000. Driving `start` with random `n`/`dataa` during CALC → ignored; result unchanged.
- Hold `clk_en` = 0 from cycle 30 of an EVAL until 10 cycles after completion → `done` rises on schedule and stays high until `clk_en` returns; then one further cycle, then IDLE.
- Assert `reset` for one cycle at cycle 40 of an EVAL_ACC → no `done`; subsequent READ returns 0x00000000.
